// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default parameter values for the run controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam int DEF_NUM_HARTS      = 1;
    localparam int DEF_CNT_W          = 32;
    localparam int DEF_HOLD_CYCLES    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 10000;
    localparam int DEF_DRAIN_CYCLES   = 1;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for cycle and retire counts.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run supervisor: holds cores in reset, times the run, waits for all harts to halt.
// Optional per-hart retire counters are built when RUN_CTRL_RETIRE_CNT_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int NUM_HARTS      = DEF_NUM_HARTS,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_HARTS-1:0] halt_i,
    input  logic [NUM_HARTS-1:0] retire_i,
    output logic                 core_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_HARTS-1:0] halted_mask,
    output logic [CNT_W-1:0]     cycle_count
`ifdef RUN_CTRL_RETIRE_CNT_EN
    ,
    output logic [NUM_HARTS*CNT_W-1:0] retire_count
`endif
);

    localparam logic [7:0]       HOLD_LAST    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]       DRAIN_LAST   = 8'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [7:0] phase_reg;
    logic       phase_clr;
    logic       run_start;
    logic       in_run;
    logic       all_halted;

    assign in_run     = (state_reg == S_RUN);
    // A halt seen this cycle counts towards completion without waiting for the mask.
    assign all_halted = &(halted_mask | halt_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_clr  = 1'b0;
        run_start  = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_next = S_HOLD;
                    phase_clr  = 1'b1;
                    run_start  = 1'b1;
                end
            end
            S_HOLD: begin
                if (phase_reg == HOLD_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Completion takes priority over reaching the limit in the same cycle.
                if (all_halted) begin
                    state_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                    phase_clr  = 1'b1;
                end else if (cycle_count == TIMEOUT_LAST) begin
                    state_next = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (phase_reg == DRAIN_LAST) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (phase_clr) begin
            phase_reg <= '0;
        end else if ((state_reg == S_HOLD) || (state_reg == S_DRAIN)) begin
            phase_reg <= phase_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_mask <= '0;
        end else if (run_start) begin
            halted_mask <= '0;
        end else if (in_run) begin
            halted_mask <= halted_mask | halt_i;
        end
    end

    always_comb begin
        core_rst_n = !((state_reg == S_IDLE) || (state_reg == S_HOLD));
        busy       = (state_reg == S_HOLD) || (state_reg == S_RUN) || (state_reg == S_DRAIN);
        done       = (state_reg == S_DONE);
        timeout    = (state_reg == S_TIMEOUT);
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .en    (in_run),
        .q     (cycle_count)
    );

`ifdef RUN_CTRL_RETIRE_CNT_EN
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HARTS; gi++) begin : g_retire
            // A hart stops counting from the cycle after its halt is recorded.
            sat_counter #(.W(CNT_W)) u_retire_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (run_start),
                .en    (in_run && retire_i[gi] && !halted_mask[gi]),
                .q     (retire_count[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate
`else
    logic unused_retire;
    assign unused_retire = ^retire_i;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized and directed bench for run_ctrl against a run-level reference model.
module tb_run_ctrl;

    localparam int NH   = 4;
    localparam int CW   = 16;
    localparam int HOLD = 4;
    localparam int TMO  = 50;
    localparam int DRN  = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;
    localparam int M_TO    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NH-1:0] halt_i = '0;
    logic [NH-1:0] retire_i = '0;
    logic          core_rst_n, busy, done, timeout;
    logic [NH-1:0] halted_mask;
    logic [CW-1:0] cycle_count;
`ifdef RUN_CTRL_RETIRE_CNT_EN
    logic [NH*CW-1:0] retire_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: run phase plus elapsed-cycle bookkeeping.
    int            m_st, m_hold, m_drain, m_cyc;
    logic [NH-1:0] m_mask;
    int            m_ret [NH];
    logic [NH-1:0] mask_at [64];

    always #5 clk = ~clk;

    run_ctrl #(
        .NUM_HARTS      (NH),
        .CNT_W          (CW),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .DRAIN_CYCLES   (DRN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_i      (halt_i),
        .retire_i    (retire_i),
        .core_rst_n  (core_rst_n),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .halted_mask (halted_mask),
        .cycle_count (cycle_count)
`ifdef RUN_CTRL_RETIRE_CNT_EN
        ,
        .retire_count(retire_count)
`endif
    );

    task automatic model_reset();
        m_st = M_IDLE; m_hold = 0; m_drain = 0; m_cyc = 0; m_mask = '0;
        for (int i = 0; i < NH; i++) m_ret[i] = 0;
    endtask

    task automatic model_step();
        case (m_st)
            M_IDLE, M_DONE, M_TO: begin
                if (start) begin
                    m_st = M_HOLD; m_hold = 0; m_cyc = 0; m_mask = '0;
                    for (int i = 0; i < NH; i++) m_ret[i] = 0;
                end
            end
            M_HOLD: begin
                m_hold++;
                if (m_hold == HOLD) m_st = M_RUN;
            end
            M_RUN: begin
                for (int i = 0; i < NH; i++)
                    if (retire_i[i] && !m_mask[i] && m_ret[i] < CMAX) m_ret[i]++;
                if (m_cyc < CMAX) m_cyc++;
                m_mask = m_mask | halt_i;
                if (m_mask == {NH{1'b1}}) begin
                    if (DRN == 0) m_st = M_DONE;
                    else begin m_st = M_DRAIN; m_drain = 0; end
                end else if (m_cyc == TMO) begin
                    m_st = M_TO;
                end
            end
            M_DRAIN: begin
                m_drain++;
                if (m_drain == DRN) m_st = M_DONE;
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic cycle(input logic s, input logic [NH-1:0] h, input logic [NH-1:0] r);
        start = s; halt_i = h; retire_i = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic          e_core, e_busy, e_done, e_to;
        logic [CW-1:0] e_cyc;
        if (chk_en) begin
            e_core = !(m_st == M_IDLE || m_st == M_HOLD);
            e_busy = (m_st == M_HOLD || m_st == M_RUN || m_st == M_DRAIN);
            e_done = (m_st == M_DONE);
            e_to   = (m_st == M_TO);
            e_cyc  = CW'(m_cyc);
            n_vec++;
            if (core_rst_n !== e_core || busy !== e_busy || done !== e_done ||
                timeout !== e_to || halted_mask !== m_mask || cycle_count !== e_cyc) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t: core_rst_n/busy/done/timeout=%b%b%b%b mask=%b cnt=%0d, required %b%b%b%b mask=%b cnt=%0d",
                         $time, core_rst_n, busy, done, timeout, halted_mask, cycle_count,
                         e_core, e_busy, e_done, e_to, m_mask, e_cyc);
            end
`ifdef RUN_CTRL_RETIRE_CNT_EN
            for (int i = 0; i < NH; i++) begin
                n_vec++;
                if (retire_count[i*CW +: CW] !== CW'(m_ret[i])) begin
                    n_err++;
                    $display("FAIL retire_cmp hart %0d t=%0t: got %0d required %0d",
                             i, $time, retire_count[i*CW +: CW], m_ret[i]);
                end
            end
`endif
        end
    end

    // mode 0: clean inputs; 1: random noise on start/halt/retire; 2: retire pattern
    task automatic run_case(input int h0, input int h1, input int h2, input int h3,
                            input int mode, output int low, output int busy_n);
        int            hat [NH];
        int            guard;
        logic [NH-1:0] h, r;
        logic          s;
        hat[0] = h0; hat[1] = h1; hat[2] = h2; hat[3] = h3;
        for (int k = 0; k < 64; k++) mask_at[k] = '0;
        cycle(1'b1, '0, '0);
        low = 0; busy_n = 0; guard = 0;
        while (!(m_st == M_DONE || m_st == M_TO) && guard < 300) begin
            if (core_rst_n !== 1'b1) low++;
            if (m_st == M_RUN || m_st == M_DRAIN) busy_n++;
            if (m_cyc < 64) mask_at[m_cyc] = halted_mask;
            for (int i = 0; i < NH; i++) begin
                if (m_st == M_RUN) h[i] = (m_cyc + 1 >= hat[i]);
                else               h[i] = (mode == 1) ? 1'($urandom) : 1'b0;
                case (mode)
                    1: r[i] = 1'($urandom);
                    2: r[i] = (m_st == M_HOLD) ||
                              (m_st == M_RUN && (m_cyc + 1 <= 12 ||
                               (i < 3 && (m_cyc + 1 == 16 || m_cyc + 1 == 17))));
                    default: r[i] = 1'b0;
                endcase
            end
            s = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            cycle(s, h, r);
            guard++;
        end
        if (guard >= 300) begin
            n_vec++; n_err++;
            $display("FAIL run_bound: run did not finish within %0d cycles", guard);
        end
        start = 1'b0; halt_i = '0; retire_i = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_mask"}, 32'(halted_mask), 0);
        chk({tag, "_cycle_count"}, 32'(cycle_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low, bn, g;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // All harts halt in the 20th RUN cycle.
        run_case(20, 20, 20, 20, 0, low, bn);
        chk("halt20_done", 32'(done), 1);
        chk("halt20_cycles", 32'(cycle_count), 20);
        chk("halt20_hold_low", 32'(low), HOLD);

        // Nobody halts: limit reached after TMO RUN cycles.
        run_case(1000, 1000, 1000, 1000, 0, low, bn);
        chk("tmo_timeout", 32'(timeout), 1);
        chk("tmo_done", 32'(done), 0);
        chk("tmo_cycles", 32'(cycle_count), 50);
        chk("tmo_hold_low", 32'(low), HOLD);

        // Staggered halts: hart0 at 5, harts1/2 at 9, hart3 at 30.
        run_case(5, 9, 9, 30, 0, low, bn);
        chk("stag_mask5", 32'(mask_at[5]), 32'h1);
        chk("stag_mask8", 32'(mask_at[8]), 32'h1);
        chk("stag_mask9", 32'(mask_at[9]), 32'h7);
        chk("stag_mask29", 32'(mask_at[29]), 32'h7);
        chk("stag_mask30", 32'(mask_at[30]), 32'hF);
        chk("stag_run_drain_cycles", 32'(bn), 32);
        chk("stag_done", 32'(done), 1);

        // Last halt coincides with the limit cycle: completion wins.
        run_case(3, 10, 50, 50, 0, low, bn);
        chk("edge_done", 32'(done), 1);
        chk("edge_timeout", 32'(timeout), 0);
        chk("edge_cycles", 32'(cycle_count), 50);

        // Retire pulses: HOLD and post-halt pulses are ignored.
        run_case(15, 15, 15, 25, 2, low, bn);
`ifdef RUN_CTRL_RETIRE_CNT_EN
        for (int i = 0; i < NH; i++)
            chk($sformatf("retire12_hart%0d", i), 32'(retire_count[i*CW +: CW]), 12);
`endif
        chk("retire_run_done", 32'(done), 1);

        // Reset in the middle of RUN aborts the run.
        cycle(1'b1, '0, '0);
        g = 0;
        while (!(m_st == M_RUN && m_cyc >= 10) && g < 100) begin
            cycle(1'b0, '0, '0);
            g++;
        end
        chk("midrun_reached", 32'(cycle_count), 10);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_case(20, 20, 20, 20, 0, low, bn);
        chk("after_reset_cycles", 32'(cycle_count), 20);
        chk("after_reset_done", 32'(done), 1);

        // Randomized runs with noise on all inputs.
        for (int n = 0; n < 14; n++) begin
            run_case($urandom_range(1, 60), $urandom_range(1, 60),
                     $urandom_range(1, 60), $urandom_range(1, 60), 1, low, bn);
            chk($sformatf("rand%0d_hold_low", n), 32'(low), HOLD);
            repeat ($urandom_range(0, 3)) cycle(1'b0, 4'($urandom), 4'($urandom));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_HARTS, default 1, giving the number of core instances supervised (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of cycle and retire counters.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 4, giving cycles core reset is held after start (1..255).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 10000, giving the run-phase cycle limit (>=1, < 2**CNT_W).
REQ-005 The block SHALL have parameter DRAIN_CYCLES, default 1, giving cycles waited after all harts halt before done (0..15).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse launching a run, accepted only in IDLE, DONE or TIMEOUT.
REQ-009 halt_i  input  NUM_HARTS  per-hart run_complete, level, sampled in RUN only.
REQ-010 retire_i  input  NUM_HARTS  per-hart instruction-retired strobe.
REQ-011 core_rst_n  output  1  active-low reset driven to all supervised cores.
REQ-012 busy  output  1  high in HOLD, RUN or DRAIN.
REQ-013 done  output  1  high in DONE until next start or reset.
REQ-014 timeout  output  1  high in TIMEOUT until next start or reset.
REQ-015 halted_mask  output  NUM_HARTS  sticky per-hart halt flags for the current run.
REQ-016 cycle_count  output  CNT_W  cycles spent in RUN for the current/last run.

Function
REQ-017 The state machine SHALL have states IDLE, HOLD, RUN, DRAIN, DONE, TIMEOUT.
REQ-018 IDLE/DONE/TIMEOUT + start SHALL go to HOLD next cycle, clearing halted_mask, cycle_count, and retire counters.
REQ-019 HOLD SHALL drive core_rst_n=0 for exactly HOLD_CYCLES cycles, then go to RUN.
REQ-020 core_rst_n SHALL be 1 in RUN, DRAIN, DONE, TIMEOUT, and 0 in IDLE and HOLD.
REQ-021 RUN SHALL increment cycle_count by 1 each cycle, saturating at all-ones.
REQ-022 In RUN, halted_mask[i] SHALL set when halt_i[i]=1 and stay set until next start.
REQ-023 When halted_mask (including same-cycle halt_i) is all-ones, RUN SHALL go to DRAIN, or straight to DONE if DRAIN_CYCLES=0.
REQ-024 When cycle_count reaches TIMEOUT_CYCLES-1 without all harts halted, RUN SHALL go to TIMEOUT; if the last halt arrives in that same cycle, DRAIN/DONE SHALL win.
REQ-025 DRAIN SHALL wait DRAIN_CYCLES cycles then go to DONE; cycle_count SHALL freeze outside RUN.
REQ-026 start in HOLD, RUN or DRAIN SHALL be ignored.
REQ-027 halt_i and retire_i outside RUN SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, core_rst_n=0, busy=0, done=0, timeout=0, halted_mask=0, cycle_count=0, retire counters=0.
REQ-029 Reset mid-run SHALL abort the run with no done or timeout indication.

Configuration
REQ-030 With RUN_CTRL_RETIRE_CNT_EN defined, the block SHALL add output retire_count (NUM_HARTS*CNT_W, hart i at bits [i*CNT_W +: CNT_W]) counting retire_i pulses in RUN only, saturating, cleared on start, and stopping per hart once that hart is halted.
REQ-031 Without RUN_CTRL_RETIRE_CNT_EN, retire_count and its counters SHALL not exist; retire_i SHALL be unused.

Structure
REQ-032 The state enum and default parameter constants SHALL live in package run_ctrl_pkg.
REQ-033 A sub-module sat_counter (width-parameterised, clear/enable, saturating) SHALL implement cycle_count and each retire counter.

Verification
REQ-034 NUM_HARTS=1, HOLD_CYCLES=4: start, halt_i rises 20 cycles into RUN -> core_rst_n low exactly 4 cycles, done=1, cycle_count=20.
REQ-035 TIMEOUT_CYCLES=50, halt_i never asserted -> timeout=1 after 50 RUN cycles, cycle_count=50, done=0.
REQ-036 NUM_HARTS=4, halts at RUN cycles 5, 9, 9, 30 -> halted_mask steps 0001, 0111, 1111; done after 30+DRAIN_CYCLES cycles.
REQ-037 Last halt on same cycle as timeout limit -> done=1, timeout=0.
REQ-038 rst_n pulsed low mid-RUN, then start -> immediate IDLE with all outputs zero; new run counts from 0.
REQ-039 With RUN_CTRL_RETIRE_CNT_EN: 12 retire pulses in RUN, 3 in HOLD, 2 after halt -> retire_count=12.
